seg7_scan_driver: RTL

- Consumes the packed 32-bit, 8-nibble display word produced by the display-formatting logic and drives a multiplexed 8-digit common-anode seven-segment panel.
- Scans one digit at a time and decodes each nibble to segments.
- Snapshots the input word once per frame to prevent tearing.
- Inserts a short anode-off guard at the start of every digit slot to suppress ghosting.

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_scan_driver_if.sv | 29 ++
 rtl/hex_to_seg7.sv | 34 +++
 rtl/seg7_scan_driver.sv | 101 ++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for seven-segment display blocks.
//   NUM_DIGITS  digits on the panel
//   SEG_0..F    active-low segment patterns {g,f,e,d,c,b,a}
//   SEG_BLANK   all segments off (active-low)
//   ANODE_OFF   all anodes off (active-low)
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0]            SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 8'hFF;

  // One frame's worth of display state, latched together so a frame never
  // mixes old and new inputs.
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] display;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp;
  } seg7_snap_t;

  // Panel drive in active-low form (an, seg, dp).
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
  } seg7_drive_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display data in, panel drive out.
//   display_in   packed nibbles, nibble k on digit k
//   digit_en     per-digit enable (0 blanks the digit)
//   dp_in        per-digit decimal point (1 = lit)
//   an/seg/dp    panel drive
//   frame_start  one-cycle pulse after each snapshot
// master = source of display data / observer of the panel; slave = the driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] display_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output display_in, digit_en, dp_in,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  display_in, digit_en, dp_in,
    output an, seg, dp, frame_start
  );

endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to seven-segment decoder.
//   hex_i  4-bit value
//   seg_o  active-low segments {g,f,e,d,c,b,a}; letters b and d are lowercase
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 8-digit common-anode seven-segment driver.
//   clk, rst  clock; asynchronous active-high reset
//   bus       seg7_scan_driver_if.slave (display inputs, panel outputs)
// Parameters:
//   DIV_CNT    clocks per digit slot (>= 2)
//   BLANK_CYC  anode-off guard cycles at the start of each slot (< DIV_CNT)
//   ACTIVE_LOW 1 = active-low an/seg/dp, 0 = all three inverted
// All panel outputs are registered: one cycle behind cnt/idx/snapshot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV_CNT    = 100000,
  parameter int BLANK_CYC  = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int CW    = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DRV_W = $bits(seg7_drive_t);

  localparam logic [CW-1:0]    CNT_MAX   = CW'(DIV_CNT - 1);
  localparam logic [CW-1:0]    BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Drive is built active-low, then flipped once here for the other polarity,
  // so the reset value follows the same inversion.
  localparam logic [DRV_W-1:0] POL_MASK = ACTIVE_LOW ? '0 : '1;
  localparam logic [DRV_W-1:0] DRV_OFF  = {ANODE_OFF, SEG_BLANK, 1'b1};

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             primed_q;
  seg7_snap_t       snap_q;
  seg7_drive_t      drv_q, drv_d;
  logic             fs_q;

  logic       tick;
  logic       cap;
  logic [3:0] nib;
  logic [6:0] nib_seg;

  assign tick = (cnt_q == CNT_MAX);
  // First edge after reset captures unconditionally; afterwards only at the
  // very end of the last digit slot, so the new frame starts on digit 0.
  assign cap  = !primed_q || (tick && idx_q == IDX_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + IDX_W'(1) : idx_q;
  end

  assign nib = snap_q.display[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex_i (nib),
    .seg_o (nib_seg)
  );

  always_comb begin
    drv_d.an  = ANODE_OFF;
    drv_d.seg = SEG_BLANK;
    drv_d.dp  = 1'b1;
    if (cnt_q >= BLANK_LIM && snap_q.digit_en[idx_q]) begin
      drv_d.an  = ~(NUM_DIGITS'(1) << idx_q);
      drv_d.seg = nib_seg;
      drv_d.dp  = ~snap_q.dp[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      primed_q <= 1'b0;
      snap_q   <= '0;
      drv_q    <= DRV_OFF ^ POL_MASK;
      fs_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      drv_q <= drv_d ^ POL_MASK;
      fs_q  <= cap;
      if (cap) begin
        primed_q        <= 1'b1;
        snap_q.display  <= bus.display_in;
        snap_q.digit_en <= bus.digit_en;
        snap_q.dp       <= bus.dp_in;
      end
    end
  end

  assign bus.an          = drv_q.an;
  assign bus.seg         = drv_q.seg;
  assign bus.dp          = drv_q.dp;
  assign bus.frame_start = fs_q;

endmodule
